cop_seq: RTL and testbench
==========================

# cop_seq

- Multi-cycle sequencer for the GCD/LCM coprocessor attached to the single-cycle RISC-V core.
- Takes the core's level-held `Start` and the packed request word, and computes GCD by iterative subtraction.
- For LCM, it also runs an iterative divide and a shift-add multiply.
- Returns the packed answer word whose `done` bit releases the core's PC-enable stall (`~Start | Start & done`).

## Interface
Parameters: none (widths fixed by the core's request/answer word format).
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  coprocessor instruction in flight; held high by the core until it sees `done`
- `WDFinal`  in  32  request word: [7:0] A, [15:8] B, [16] op (0 = GCD, 1 = LCM), [31:17] ignored
- `copAns`  out  32  answer: [7:0] result, [8] done, [9] busy, [10] ovf, [31:11] zero

## Operation
- All copAns fields reset to 0 and the FSM resets to IDLE. Regs: `a`, `b`, `a0`, `b0`, `op`, `g`, `rem`, `q`, `prod[15:0]`, `mcnt[3:0]`, `res[7:0]`, `ovf`.
- **IDLE:** if `Start`, latch `a = a0 = WDFinal[7:0]`, `b = b0 = WDFinal[15:8]`, `op = WDFinal[16]`, clear `ovf`, go to GCD.
- **GCD (one step per cycle):**
  - If `a==0 | b==0 | a==b`: set `g = (a==0) ? b : a`.
    - op=0: `res = g`, go to DONE.
    - op=1 with `a0==0 | b0==0`: `res = 0`, go to DONE.
    - Otherwise: `rem = a0`, `q = 0`, go to DIV.
  - Else subtract the smaller operand from the larger.
- **DIV:** `rem -= g`, `q += 1` each cycle. On the cycle where `rem - g == 0`, go to MUL with `prod = 0`, `mcnt = 0`.
- **MUL:** 8 cycles of shift-add computing `prod = q * b0` (16-bit, LSB-first on `q`). After the 8th cycle: `res = prod[7:0]`, `ovf = |prod[15:8]`, go to DONE.
- **DONE:** exactly one cycle with `done = 1`, then unconditionally return to IDLE. If the next instruction is also a coprocessor op, `Start` is still high in IDLE and a new request is captured.
- `busy = 1` in GCD, DIV and MUL.
- `res` and `ovf` hold their values until the next completion or reset.
- Arithmetic is unsigned 8-bit. `gcd(0,0) = 0`. `lcm(x,0) = lcm(0,x) = 0`.
- **Abort:** if `Start` is low in GCD, DIV or MUL, return to IDLE next edge. `done` is not asserted and `res` is unchanged.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0.

## Timing
- Capture happens at edge E0, where `Start` is first sampled high in IDLE.
- Let k = number of GCD subtractions and m = a0/g.
- GCD: `done` rises at E0 + k + 1 and falls one edge later.
- LCM (nonzero operands): `done` rises at E0 + k + 1 + m + 8.
- Worst case is LCM(255,254) at 518 edges.
- The core's register write and PC advance occur at the edge ending the DONE cycle, so `copAns[7:0]` must be stable throughout DONE.
- `copAns` is fully registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `cop_pkg` holds:
  - state enum `{IDLE, GCD, DIV, MUL, DONE}`
  - request field positions: `A_LSB = 0`, `B_LSB = 8`, `OP_BIT = 16`
  - answer bit positions: `DONE_BIT = 8`, `BUSY_BIT = 9`, `OVF_BIT = 10`
- One sub-module, `mul8_shiftadd`: an 8-cycle sequential 8x8->16 multiplier with `go`/`fin` handshake. MUL waits on its `fin`.
- The GCD/DIV step logic stays inline in `cop_seq`.

## Test plan
- **GCD(12,8), op=0:** `done` high for one cycle at E0+3, `result = 0x04`, `busy` high E0..E0+2, `ovf = 0`.
- **LCM(12,8), op=1:** `done` at E0+14, `result = 0x18`, `ovf = 0`. Then `Start` stays high with a new word GCD(9,6): captured in the following IDLE cycle, `result = 0x03`.
- **LCM(16,17):** `done` at E0+41, `result = 0x10`, `ovf = 1`.
- **Zero operands:**
  - GCD(0,7) gives 0x07 at E0+1.
  - LCM(0,7) gives 0x00 at E0+1.
  - GCD(0,0) gives 0x00.
- **Abort:** drop `Start` during DIV of LCM(200,3). FSM returns to IDLE next edge, `done` never rises, `result` keeps its prior value.
- **Reset:** pull `reset` low mid-MUL. `copAns == 0` asynchronously. After release, GCD(5,5) completes at E0+1 with 0x05.

Source files
------------

// File: rtl/cop_pkg.sv
// -----------------------------------------------------------------------------
// cop_pkg
// Shared definitions for the GCD/LCM coprocessor sequencer.
//   - state_t      : sequencer FSM states
//   - *_LSB/*_BIT  : field positions inside the request word (WDFinal) and
//                    the answer word (copAns)
//   - pack_ans()   : assembles the answer word from its fields
// -----------------------------------------------------------------------------
package cop_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GCD  = 3'd1,
    DIV  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Request word fields
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 8;
  localparam int OP_BIT = 16;

  // Answer word fields; [7:0] is the result, bits above OVF_BIT read as zero
  localparam int DONE_BIT = 8;
  localparam int BUSY_BIT = 9;
  localparam int OVF_BIT  = 10;

  function automatic logic [31:0] pack_ans(input logic [7:0] res,
                                           input logic       done,
                                           input logic       busy,
                                           input logic       ovf);
    logic [31:0] w;
    w           = '0;
    w[7:0]      = res;
    w[DONE_BIT] = done;
    w[BUSY_BIT] = busy;
    w[OVF_BIT]  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/cop_seq_if.sv
// -----------------------------------------------------------------------------
// cop_seq_if
// Core <-> coprocessor connection.
//   Start   : core -> cop, level-held while a coprocessor instruction is in flight
//   WDFinal : core -> cop, packed request word {ignored, op, B, A}
//   copAns  : cop -> core, packed answer word {zero, ovf, busy, done, result}
//
// Handshake: the request is accepted on the clock edge where Start is high
// and the sequencer is idle. The core keeps Start (and WDFinal) stable until
// it samples done = 1; done is a single-cycle pulse, and the result byte is
// valid for that entire cycle. Dropping Start before done abandons the
// request; no done is produced for it.
// -----------------------------------------------------------------------------
interface cop_seq_if;
  logic        Start;
  logic [31:0] WDFinal;
  logic [31:0] copAns;

  modport master (output Start, output WDFinal, input copAns);
  modport slave  (input  Start, input  WDFinal, output copAns);
endinterface

// File: rtl/mul8_shiftadd.sv
// -----------------------------------------------------------------------------
// mul8_shiftadd
// Sequential 8x8 -> 16 unsigned multiplier, one shift-add step per cycle,
// LSB-first on the multiplier. Eight steps per product.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   go          : load operands this edge and start (takes priority over abort)
//   abort       : stop a running product; nothing is reported
//   mplier      : multiplier, consumed LSB first
//   mcand       : multiplicand
//   fin         : high during the 8th step; prod_next is the final product then
//   prod_next   : accumulator value after the current step
// -----------------------------------------------------------------------------
module mul8_shiftadd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  input  logic [7:0]  mplier,
  input  logic [7:0]  mcand,
  output logic        fin,
  output logic [15:0] prod_next
);

  logic        run_q,  run_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [7:0]  mq_q,   mq_d;
  logic [15:0] mb_q,   mb_d;
  logic [15:0] prod_q, prod_d;
  logic [15:0] addend;

  always_comb begin
    run_d  = run_q;
    mcnt_d = mcnt_q;
    mq_d   = mq_q;
    mb_d   = mb_q;
    prod_d = prod_q;

    addend    = mq_q[0] ? mb_q : 16'd0;
    prod_next = prod_q + addend;
    // fin is combinational so the sequencer can take the product on the same
    // edge that performs the last step, without an extra cycle.
    fin       = run_q && (mcnt_q == 4'd7);

    if (go) begin
      run_d  = 1'b1;
      mcnt_d = 4'd0;
      mq_d   = mplier;
      mb_d   = {8'd0, mcand};
      prod_d = 16'd0;
    end else if (abort) begin
      run_d = 1'b0;
    end else if (run_q) begin
      prod_d = prod_next;
      mq_d   = mq_q >> 1;
      mb_d   = mb_q << 1;
      mcnt_d = mcnt_q + 4'd1;
      if (mcnt_q == 4'd7) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      mcnt_q <= 4'd0;
      mq_q   <= 8'd0;
      mb_q   <= 16'd0;
      prod_q <= 16'd0;
    end else begin
      run_q  <= run_d;
      mcnt_q <= mcnt_d;
      mq_q   <= mq_d;
      mb_q   <= mb_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/cop_seq.sv
// -----------------------------------------------------------------------------
// cop_seq
// Multi-cycle sequencer for the GCD/LCM coprocessor of the single-cycle core.
// GCD by repeated subtraction; LCM = (a0 / g) * b0, where the division is
// repeated subtraction of g and the multiply is done by mul8_shiftadd.
//
// Ports
//   clk       : core clock
//   reset     : asynchronous active-low reset
//   bus       : cop_seq_if slave (Start, WDFinal in; copAns out)
//   state_dbg : current FSM state
//
// Answer word is built only from flops: done/busy are registered from the
// next state, so nothing in copAns depends combinationally on the inputs.
// -----------------------------------------------------------------------------
module cop_seq
  import cop_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  cop_seq_if.slave   bus,
  output state_t     state_dbg
);

  state_t     state_q, state_d;
  logic [7:0] a_q,   a_d;
  logic [7:0] b_q,   b_d;
  logic [7:0] a0_q,  a0_d;
  logic [7:0] b0_q,  b0_d;
  logic       op_q,  op_d;
  logic [7:0] g_q,   g_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] q_q,   q_d;
  logic [7:0] res_q, res_d;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic [7:0]  g_sel;
  logic [7:0]  rem_next;
  logic [7:0]  q_next;
  logic        gcd_end;
  logic        mul_go;
  logic        mul_abort;
  logic        mul_fin;
  logic [15:0] mul_prod;
  logic        unused_wd_hi;

  assign unused_wd_hi = ^bus.WDFinal[31:17];

  // GCD terminates when either operand is zero or both are equal; the
  // nonzero one (or b when a is zero, which also covers gcd(0,0)=0) is g.
  assign gcd_end  = (a_q == 8'd0) || (b_q == 8'd0) || (a_q == b_q);
  assign g_sel    = (a_q == 8'd0) ? b_q : a_q;
  assign rem_next = rem_q - g_q;
  assign q_next   = q_q + 8'd1;

  // The multiplier loads on the DIV exit edge, when q_next is the final
  // quotient a0/g.
  mul8_shiftadd u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .go        (mul_go),
    .abort     (mul_abort),
    .mplier    (q_next),
    .mcand     (b0_q),
    .fin       (mul_fin),
    .prod_next (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    a0_d      = a0_q;
    b0_d      = b0_q;
    op_d      = op_q;
    g_d       = g_q;
    rem_d     = rem_q;
    q_d       = q_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    mul_go    = 1'b0;
    mul_abort = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.WDFinal[A_LSB +: 8];
          a0_d    = bus.WDFinal[A_LSB +: 8];
          b_d     = bus.WDFinal[B_LSB +: 8];
          b0_d    = bus.WDFinal[B_LSB +: 8];
          op_d    = bus.WDFinal[OP_BIT];
          ovf_d   = 1'b0;
          state_d = GCD;
        end
      end

      GCD: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else if (gcd_end) begin
          g_d = g_sel;
          if (!op_q) begin
            res_d   = g_sel;
            state_d = DONE;
          end else if ((a0_q == 8'd0) || (b0_q == 8'd0)) begin
            res_d   = 8'd0;
            state_d = DONE;
          end else begin
            rem_d   = a0_q;
            q_d     = 8'd0;
            state_d = DIV;
          end
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      DIV: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next;
          q_d   = q_next;
          if (rem_next == 8'd0) begin
            mul_go  = 1'b1;
            state_d = MUL;
          end
        end
      end

      MUL: begin
        if (!bus.Start) begin
          mul_abort = 1'b1;
          state_d   = IDLE;
        end else if (mul_fin) begin
          res_d   = mul_prod[7:0];
          ovf_d   = |mul_prod[15:8];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == GCD) || (state_d == DIV) || (state_d == MUL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      a0_q    <= 8'd0;
      b0_q    <= 8'd0;
      op_q    <= 1'b0;
      g_q     <= 8'd0;
      rem_q   <= 8'd0;
      q_q     <= 8'd0;
      res_q   <= 8'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      op_q    <= op_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.copAns = pack_ans(res_q, done_q, busy_q, ovf_q);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cop_seq.sv
// -----------------------------------------------------------------------------
// tb_cop_seq
// Scoreboarded bench for cop_seq: directed cases, abort, reset mid-operation,
// then randomized GCD/LCM requests (some back-to-back with Start held high).
// -----------------------------------------------------------------------------
module tb_cop_seq;
  import cop_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;
  int     cyc = 0;

  cop_seq_if bus ();

  cop_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];      // {ovf, result}
  int         exp_cyc_q[$];  // cycle number at which done must be seen
  int         checks   = 0;
  int         failures = 0;
  int         last_res = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // g by Euclid's modulo form, k by counting subtraction steps, lcm by a*b/g.
  task automatic model(input int a, input int b, input int op,
                       output int res, output int ovf, output int lat);
    int x, y, t, g, k, p, r, l;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    g = x;
    p = a; r = b; k = 0;
    while (p != 0 && r != 0 && p != r) begin
      if (p > r) p = p - r; else r = r - p;
      k++;
    end
    if (op == 0) begin
      res = g; ovf = 0; lat = k + 1;
    end else if (a == 0 || b == 0) begin
      res = 0; ovf = 0; lat = k + 1;
    end else begin
      l   = (a * b) / g;
      res = l % 256;
      ovf = (l > 255) ? 1 : 0;
      lat = k + 1 + (a / g) + 8;
    end
  endtask

  // ---------------- driver ----------------
  // b2b: called in the DONE cycle of the previous op with Start still high.
  // hold_after: keep Start high after done so the next call can be b2b.
  task automatic do_op(input int a, input int b, input int op,
                       input bit b2b, input bit hold_after);
    int res, ovf, lat, e0, n;
    logic [14:0] junk;
    model(a, b, op, res, ovf, lat);
    if (!b2b) @(negedge clk);
    junk        = 15'($urandom);
    bus.WDFinal = {junk, 1'(op), 8'(b), 8'(a)};
    bus.Start   = 1'b1;
    e0 = b2b ? cyc + 2 : cyc + 1;
    exp_q.push_back({1'(ovf), 8'(res)});
    exp_cyc_q.push_back(e0 + lat);
    last_res = res;
    while (cyc < e0) @(negedge clk);
    check("busy_after_capture", {31'd0, bus.copAns[BUSY_BIT]}, 32'd1);
    n = 0;
    while (!bus.copAns[DONE_BIT] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus.copAns[DONE_BIT]) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done for a=%0d b=%0d op=%0d", a, b, op);
    end
    if (!hold_after) bus.Start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic       prev_done = 1'b0;
  logic [8:0] exp_w;
  int         exp_c;

  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", {31'd0, bus.copAns[DONE_BIT]}, 32'd0);
      if (bus.copAns[DONE_BIT]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected none pending (cycle %0d)", cyc);
        end else begin
          exp_w = exp_q.pop_front();
          exp_c = exp_cyc_q.pop_front();
          check("result",     {24'd0, bus.copAns[7:0]},       {24'd0, exp_w[7:0]});
          check("ovf",        {31'd0, bus.copAns[OVF_BIT]},   {31'd0, exp_w[8]});
          check("done_cycle", cyc,                            exp_c);
          check("busy_in_done", {31'd0, bus.copAns[BUSY_BIT]}, 32'd0);
          check("upper_zero", {11'd0, bus.copAns[31:11]},     32'd0);
        end
      end
      prev_done = bus.copAns[DONE_BIT];
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int  e0, dn;
    bit  hold, prev_hold;
    int  ra, rb, rop;

    reset       = 1'b0;
    bus.Start   = 1'b0;
    bus.WDFinal = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_copans", bus.copAns, 32'd0);
    check("reset_state",  state_dbg,  IDLE);
    reset = 1'b1;

    // Directed cases
    do_op(12, 8, 0, 1'b0, 1'b0);
    do_op(12, 8, 1, 1'b0, 1'b1);
    do_op(9, 6, 0, 1'b1, 1'b0);
    do_op(16, 17, 1, 1'b0, 1'b0);
    do_op(0, 7, 0, 1'b0, 1'b0);
    do_op(0, 7, 1, 1'b0, 1'b0);
    do_op(0, 0, 0, 1'b0, 1'b0);
    do_op(7, 0, 1, 1'b0, 1'b0);
    do_op(255, 254, 1, 1'b0, 1'b0);

    // Abort during DIV of LCM(200,3): GCD takes 68 steps, DIV spans 200 cycles
    @(negedge clk);
    bus.WDFinal = {15'd0, 1'b1, 8'd3, 8'd200};
    bus.Start   = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 75) @(negedge clk);
    check("abort_in_div", state_dbg, DIV);
    bus.Start = 1'b0;
    @(negedge clk);
    check("abort_state",  state_dbg, IDLE);
    check("abort_result", {24'd0, bus.copAns[7:0]}, 32'(last_res));
    check("abort_flags",  {29'd0, bus.copAns[OVF_BIT], bus.copAns[BUSY_BIT], bus.copAns[DONE_BIT]}, 32'd0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.copAns[DONE_BIT]) dn++;
    end
    check("abort_no_done", dn, 0);

    // Reset in the middle of MUL for LCM(12,8) (MUL occupies E0+7..E0+14)
    @(negedge clk);
    bus.WDFinal = {15'd0, 1'b1, 8'd8, 8'd12};
    bus.Start   = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 10) @(negedge clk);
    check("reset_mid_mul_state", state_dbg, MUL);
    reset = 1'b0;
    #1;
    check("reset_async_copans", bus.copAns, 32'd0);
    check("reset_async_state",  state_dbg,  IDLE);
    bus.Start = 1'b0;
    last_res  = 0;
    @(negedge clk);
    reset = 1'b1;
    do_op(5, 5, 0, 1'b0, 1'b0);

    // Randomized requests
    prev_hold = 1'b0;
    for (int i = 0; i < 25; i++) begin
      ra   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
      rb   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
      rop  = $urandom_range(0, 1);
      hold = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op(ra, rb, rop, prev_hold, hold);
      prev_hold = hold;
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
